// File: rtl/tensor_tile_loader.sv
// Streams 128-bit matrix rows into bfloat16 A/B tiles and an fp32 C tile for a 4x4 tensor core.
// Optional macro TILE_LOADER_CZERO_EN adds a c_zero input that can skip the C load and zero C_o instead.
module tensor_tile_loader (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] row_data,
    output logic [15:0]  A_o [0:3][0:3],
    output logic [15:0]  B_o [0:3][0:3],
    output logic [31:0]  C_o [0:3][0:3],
    output logic         tile_valid,
    input  logic         tile_ready,
`ifdef TILE_LOADER_CZERO_EN
    input  logic         c_zero,
`endif
    output logic [1:0]   phase
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        LOAD_C = 2'd2,
        FULL   = 2'd3
    } state_t;

    state_t      state_reg;
    logic [1:0]  row_reg;
    logic [31:0] lane [0:3];
    logic        accept;
    logic        last_row;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = row_data[32*gi +: 32];
    end

    assign accept   = in_valid && in_ready;
    assign last_row = (row_reg == 2'd3);
    assign phase    = state_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= LOAD_A;
            row_reg    <= 2'd0;
            tile_valid <= 1'b0;
            in_ready   <= 1'b1;
            for (int r = 0; r < 4; r++) begin
                for (int k = 0; k < 4; k++) begin
                    A_o[r][k] <= '0;
                    B_o[r][k] <= '0;
                    C_o[r][k] <= '0;
                end
            end
        end else begin
            case (state_reg)
                LOAD_A: begin
                    if (accept) begin
                        for (int k = 0; k < 4; k++) A_o[row_reg][k] <= lane[k][15:0];
                        row_reg <= row_reg + 2'd1;
                        if (last_row) state_reg <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        for (int k = 0; k < 4; k++) B_o[row_reg][k] <= lane[k][15:0];
                        row_reg <= row_reg + 2'd1;
                        if (last_row) begin
`ifdef TILE_LOADER_CZERO_EN
                            // Zero-accumulator tile: skip the C rows entirely
                            if (c_zero) begin
                                for (int r = 0; r < 4; r++) begin
                                    for (int k = 0; k < 4; k++) C_o[r][k] <= '0;
                                end
                                state_reg  <= FULL;
                                tile_valid <= 1'b1;
                                in_ready   <= 1'b0;
                            end else begin
                                state_reg <= LOAD_C;
                            end
`else
                            state_reg <= LOAD_C;
`endif
                        end
                    end
                end
                LOAD_C: begin
                    if (accept) begin
                        for (int k = 0; k < 4; k++) C_o[row_reg][k] <= lane[k];
                        row_reg <= row_reg + 2'd1;
                        if (last_row) begin
                            state_reg  <= FULL;
                            tile_valid <= 1'b1;
                            in_ready   <= 1'b0;
                        end
                    end
                end
                FULL: begin
                    // Tiles stay visible after release until overwritten row by row
                    if (tile_ready) begin
                        state_reg  <= LOAD_A;
                        tile_valid <= 1'b0;
                        in_ready   <= 1'b1;
                    end
                end
                default: state_reg <= LOAD_A;
            endcase
        end
    end

endmodule

// File: tb/tb_tensor_tile_loader.sv
// Self-checking bench for tensor_tile_loader: directed table, gap/hold/reset sequences,
// identity end-to-end product, and randomized traffic against a beat-count reference model.
module tb_tensor_tile_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] row_data;
    logic [15:0]  a_o [0:3][0:3];
    logic [15:0]  b_o [0:3][0:3];
    logic [31:0]  c_o [0:3][0:3];
    logic         tile_valid;
    logic         tile_ready;
    logic [1:0]   phase;
`ifdef TILE_LOADER_CZERO_EN
    logic         c_zero = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tensor_tile_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .row_data  (row_data),
        .A_o       (a_o),
        .B_o       (b_o),
        .C_o       (c_o),
        .tile_valid(tile_valid),
        .tile_ready(tile_ready),
`ifdef TILE_LOADER_CZERO_EN
        .c_zero    (c_zero),
`endif
        .phase     (phase)
    );

    // Reference model: counts accepted beats of the current tile
    int          m_cnt;
    bit          m_full;
    logic [31:0] m_a [4][4];
    logic [31:0] m_b [4][4];
    logic [31:0] m_c [4][4];

    task automatic model_reset();
        m_cnt  = 0;
        m_full = 0;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                m_a[r][k] = 0; m_b[r][k] = 0; m_c[r][k] = 0;
            end
    endtask

    task automatic model_step(input bit iv, input bit tr, input logic [127:0] d, input bit cz);
        int mat, r;
        if (m_full) begin
            if (tr) m_full = 0;
        end else if (iv) begin
            mat = m_cnt / 4;
            r   = m_cnt % 4;
            for (int k = 0; k < 4; k++) begin
                if (mat == 0) m_a[r][k] = {16'h0, d[32*k +: 16]};
                if (mat == 1) m_b[r][k] = {16'h0, d[32*k +: 16]};
                if (mat == 2) m_c[r][k] = d[32*k +: 32];
            end
            m_cnt++;
            if (m_cnt == 8 && cz) begin
                for (int i = 0; i < 4; i++)
                    for (int k = 0; k < 4; k++) m_c[i][k] = 0;
                m_cnt = 0; m_full = 1;
            end else if (m_cnt == 12) begin
                m_cnt = 0; m_full = 1;
            end
        end
    endtask

    task automatic cmp(input string name, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [511:0] ga, ea, gb, eb, gc, ec;
        ga = '0; ea = '0; gb = '0; eb = '0; gc = '0; ec = '0;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                ga[(r*4+k)*16 +: 16] = a_o[r][k];
                ea[(r*4+k)*16 +: 16] = m_a[r][k][15:0];
                gb[(r*4+k)*16 +: 16] = b_o[r][k];
                eb[(r*4+k)*16 +: 16] = m_b[r][k][15:0];
                gc[(r*4+k)*32 +: 32] = c_o[r][k];
                ec[(r*4+k)*32 +: 32] = m_c[r][k];
            end
        cmp({tag, ".phase"}, 512'(phase), m_full ? 512'd3 : 512'(m_cnt / 4));
        cmp({tag, ".in_ready"}, 512'(in_ready), 512'(!m_full));
        cmp({tag, ".tile_valid"}, 512'(tile_valid), 512'(m_full));
        cmp({tag, ".A_o"}, ga, ea);
        cmp({tag, ".B_o"}, gb, eb);
        cmp({tag, ".C_o"}, gc, ec);
    endtask

    task automatic step(input string tag, input bit iv, input bit tr, input logic [127:0] d);
        bit cz = 0;
`ifdef TILE_LOADER_CZERO_EN
        cz = c_zero;
`endif
        in_valid = iv; tile_ready = tr; row_data = d;
        @(posedge clk);
        model_step(iv, tr, d, cz);
        #1;
        check_all(tag);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic real f32r(input logic [31:0] b);
        int  e;
        real v;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -v : v;
    endfunction

    typedef struct {
        bit           iv;
        bit           tr;
        logic [127:0] d;
        logic [1:0]   ph;
        bit           rdy;
        bit           tv;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [127:0] d;
        logic [511:0] gd, ed;
        int           beats, cycles;

        // Table for the basic back-to-back tile with junk in the upper lane halves
        for (int i = 0; i < 14; i++) begin
            d = '0;
            for (int k = 0; k < 4; k++)
                d[32*k +: 32] = (i < 8) ? {16'hFFFF, 16'(16'h3F80 + k)} : 32'h3F800000;
            tbl[i].iv  = 1;
            tbl[i].tr  = (i == 13);
            tbl[i].d   = (i < 12) ? d : rnd128();
            tbl[i].ph  = (i >= 11 && i < 13) ? 2'd3 : (i == 13 ? 2'd0 : 2'((i + 1) / 4));
            tbl[i].rdy = !(i >= 11 && i < 13);
            tbl[i].tv  = (i >= 11 && i < 13);
        end

        rst = 1; in_valid = 0; tile_ready = 0; row_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 0;

        for (int i = 0; i < 14; i++) begin
            step("tbl", tbl[i].iv, tbl[i].tr, tbl[i].d);
            cmp($sformatf("tbl%0d.phase", i), 512'(phase), 512'(tbl[i].ph));
            cmp($sformatf("tbl%0d.in_ready", i), 512'(in_ready), 512'(tbl[i].rdy));
            cmp($sformatf("tbl%0d.tile_valid", i), 512'(tile_valid), 512'(tbl[i].tv));
        end
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                cmp($sformatf("tbl.A[%0d][%0d]", r, k), 512'(a_o[r][k]), 512'(16'h3F80 + k));
                cmp($sformatf("tbl.B[%0d][%0d]", r, k), 512'(b_o[r][k]), 512'(16'h3F80 + k));
                cmp($sformatf("tbl.C[%0d][%0d]", r, k), 512'(c_o[r][k]), 512'h3F800000);
            end

        // Alternate-cycle gaps, then a 5-cycle FULL hold with in_valid high
        for (int i = 0; i < 24; i++) step("gap", (i % 2) == 0, 0, rnd128());
        cmp("gap.tile_valid_after_12", 512'(tile_valid), 512'd1);
        for (int i = 0; i < 5; i++) step("hold", 1, 0, rnd128());
        step("release", 1, 1, rnd128());
        cmp("release.phase", 512'(phase), 512'd0);

        // Asynchronous reset in LOAD_B row 1
        for (int i = 0; i < 6; i++) step("pre_rst", 1, 0, rnd128());
        cmp("pre_rst.phase", 512'(phase), 512'd1);
        #2 rst = 1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 12; i++) step("fresh", 1, 0, rnd128());
        cmp("fresh.tile_valid", 512'(tile_valid), 512'd1);
        step("fresh_rel", 0, 1, '0);

        // Identity A and B with zero C through a behavioural core
        for (int i = 0; i < 12; i++) begin
            d = '0;
            if (i < 8) d[32*(i % 4) +: 16] = 16'h3F80;
            step("ident", 1, 0, d);
        end
        gd = '0; ed = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                real acc;
                acc = f32r(c_o[i][j]);
                for (int k = 0; k < 4; k++)
                    acc += f32r({a_o[i][k], 16'h0}) * f32r({b_o[k][j], 16'h0});
                gd[(i*4+j)*32 +: 32] = (acc == 1.0) ? 32'h3F800000 : (acc == 0.0 ? 32'h0 : 32'hFFFFFFFF);
                ed[(i*4+j)*32 +: 32] = (i == j) ? 32'h3F800000 : 32'h0;
            end
        cmp("ident.tile_valid", 512'(tile_valid), 512'd1);
        cmp("ident.D", gd, ed);
        step("ident_rel", 0, 1, '0);

`ifdef TILE_LOADER_CZERO_EN
        // c_zero tile takes 8 beats, the next ordinary tile takes 12
        cycles = 0;
        c_zero = 1;
        for (int i = 0; i < 8; i++) step("cz", 1, 0, rnd128());
        c_zero = 0;
        cmp("cz.tile_valid_8", 512'(tile_valid), 512'd1);
        step("cz_rel", 1, 1, rnd128());
        for (int i = 0; i < 11; i++) step("cz_next", 1, 0, rnd128());
        cmp("cz_next.not_full_11", 512'(tile_valid), 512'd0);
        step("cz_next", 1, 0, rnd128());
        cmp("cz_next.full_12", 512'(tile_valid), 512'd1);
        step("cz_next_rel", 0, 1, '0);
`endif

        // Randomized traffic, bounded by a cycle budget
        beats = 0;
        for (cycles = 0; cycles < 600; cycles++) begin
            bit iv;
`ifdef TILE_LOADER_CZERO_EN
            c_zero = 1'($urandom_range(0, 1));
`endif
            iv = ($urandom_range(0, 3) != 0);
            if (iv && in_ready) beats++;
            step("rand", iv, 1'($urandom_range(0, 1)), rnd128());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tensor_tile_loader.md
TENSOR_TILE_LOADER -- requirements
Module: tensor_tile_loader

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  row beat present on row_data.
REQ-004 SHALL have port: in_ready  output  1  loader accepts a beat this cycle.
REQ-005 SHALL have port: row_data  input  128  one matrix row; lane k = row_data[32k+31:32k] = column k.
REQ-006 SHALL have port: A_o  output  [15:0] x [0:3][0:3]  bfloat16 A tile to the tensor core.
REQ-007 SHALL have port: B_o  output  [15:0] x [0:3][0:3]  bfloat16 B tile to the tensor core.
REQ-008 SHALL have port: C_o  output  [31:0] x [0:3][0:3]  fp32 accumulator tile to the tensor core.
REQ-009 SHALL have port: tile_valid  output  1  A_o/B_o/C_o hold a complete tile.
REQ-010 SHALL have port: tile_ready  input  1  consumer has captured the core result D.
REQ-011 SHALL have port: phase  output  2  current state encoding (0 LOAD_A, 1 LOAD_B, 2 LOAD_C, 3 FULL).

Function
REQ-012 SHALL implement FSM states LOAD_A, LOAD_B, LOAD_C, FULL with a 2-bit row counter.
REQ-013 SHALL accept a beat when in_valid && in_ready; in_ready = 1 in LOAD_A/LOAD_B/LOAD_C, 0 in FULL.
REQ-014 SHALL load beat r of LOAD_A into A_o[r][k] = lane k bits [15:0]; lane bits [31:16] ignored.
REQ-015 SHALL load beat r of LOAD_B into B_o[r][k] = lane k bits [15:0]; lane bits [31:16] ignored.
REQ-016 SHALL load beat r of LOAD_C into C_o[r][k] = full 32-bit lane k.
REQ-017 SHALL increment row counter per accepted beat; on row 3 accepted, counter wraps to 0 and state advances A->B->C->FULL.
REQ-018 SHALL hold state, counter and tile registers unchanged on cycles with no accepted beat (in_valid gaps anywhere legal).
REQ-019 SHALL drive tile_valid = 1 exactly while in FULL, registered, asserted the cycle after the last C beat is accepted.
REQ-020 SHALL, in FULL with tile_ready = 1, return to LOAD_A next cycle; A_o/B_o/C_o retain values until overwritten row by row.
REQ-021 SHALL ignore tile_ready outside FULL.
REQ-022 SHALL have minimum tile period 13 cycles (12 beats + 1 FULL cycle) with continuous in_valid and tile_ready.

Reset
REQ-023 SHALL, on rst assertion (any time, including mid-load), immediately enter LOAD_A, clear row counter, clear A_o/B_o/C_o to 0, tile_valid to 0, phase to 0; in_ready = 1 after deassertion.
REQ-024 SHALL discard any partially loaded tile on reset; the first beat after reset is A row 0.

Configuration
REQ-025 SHALL support macro TILE_LOADER_CZERO_EN; when defined, adds input port c_zero (1 bit).
REQ-026 With TILE_LOADER_CZERO_EN, c_zero sampled on the accepted LOAD_B row-3 beat; if 1, LOAD_C skipped, C_o cleared to 0, FULL entered next cycle (8-beat tile); if 0, behaviour as REQ-016.
REQ-027 Without TILE_LOADER_CZERO_EN, no c_zero port exists and every tile is 12 beats.

Verification
REQ-028 Reset then 12 back-to-back beats, row_data lane k = {16'hFFFF, 16'h3F80+k} for A/B, 32'h3F800000 for C -> A_o/B_o all 16'h3F8k by column, C_o all 32'h3F800000, tile_valid rises cycle 13, upper lanes ignored.
REQ-029 Same tile with in_valid low on alternate cycles -> identical tile contents, tile_valid after the 12th accepted beat only, in_ready never drops before FULL.
REQ-030 In FULL hold tile_ready = 0 for 5 cycles with in_valid = 1 -> in_ready = 0, no beat consumed, outputs stable; tile_ready = 1 -> phase = 0 next cycle.
REQ-031 Assert rst after 6 accepted beats (in LOAD_B row 1) -> all outputs zero same cycle, phase 0; next 12 beats form a correct fresh tile.
REQ-032 With TILE_LOADER_CZERO_EN, c_zero = 1 on B row-3 beat -> tile_valid after 8 beats, C_o all 0; following tile with c_zero = 0 takes 12 beats.
REQ-033 End-to-end: loader feeding the bfloat16 tensor core, A = B = identity (16'h3F80 diagonal), C = 0 -> core D equals identity (32'h3F800000 diagonal) while tile_valid = 1.
